// File: rtl/ff_ram_2p_clr.sv
// Flip-flop RAM with one write port and one read port, per-byte write mask,
// 1- or 2-cycle read latency, optional read-during-write forwarding and a word-per-cycle clear engine.
module ff_ram_2p_clr #(
  parameter int DW      = 32,
  parameter int AW      = 10,
  parameter int MEMSIZE = 1024,
  parameter int RD_LAT  = 1,
  parameter int BYPASS  = 1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            clear,
  output logic            busy,
  input  logic            csb0,
  input  logic [AW-1:0]   addr0,
  input  logic [DW-1:0]   din0,
  input  logic [DW/8-1:0] wmask0,
  input  logic            csb1,
  input  logic [AW-1:0]   addr1,
  output logic [DW-1:0]   dout1,
  output logic            dvalid1
);

  localparam int          NB        = DW / 8;
  localparam int          IW        = (MEMSIZE > 1) ? $clog2(MEMSIZE) : 1;
  localparam logic [AW:0] MEM_LIMIT = (AW+1)'(MEMSIZE);
  localparam logic [AW-1:0] LAST    = AW'(MEMSIZE - 1);

  typedef enum logic {S_CLEAR, S_IDLE} state_t;

  state_t          state, state_nxt;
  logic [AW-1:0]   clr_addr, clr_addr_nxt;
  logic            port_en, wr_en, rd_en;
  logic [DW-1:0]   rd_word;
  logic [DW-1:0]   mem [MEMSIZE];

  function automatic logic in_range(input logic [AW-1:0] a);
    return {1'b0, a} < MEM_LIMIT;
  endfunction

  function automatic logic [IW-1:0] idx(input logic [AW-1:0] a);
    return a[IW-1:0];
  endfunction

  // NOTE: non-blocking assignments for every state register so all flops update together at the edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_CLEAR;
      clr_addr <= '0;
    end else begin
      state    <= state_nxt;
      clr_addr <= clr_addr_nxt;
    end
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_nxt    = state;
    clr_addr_nxt = clr_addr;
    case (state)
      S_CLEAR: begin
        clr_addr_nxt = clr_addr + 1'b1;
        if (clr_addr == LAST) begin
          state_nxt    = S_IDLE;
          clr_addr_nxt = '0;
        end
      end
      S_IDLE: begin
        if (clear) begin
          state_nxt    = S_CLEAR;
          clr_addr_nxt = '0;
        end
      end
      default: state_nxt = S_CLEAR;
    endcase
  end

  assign busy    = (state == S_CLEAR);
  // A clear request in IDLE takes the cycle: the ports see nothing that edge.
  assign port_en = (state == S_IDLE) && !clear;
  assign wr_en   = port_en && !csb0 && in_range(addr0);
  assign rd_en   = port_en && !csb1;

  // NOTE: the array has no reset; the clear engine zeroes it after reset release instead.
  always_ff @(posedge clk) begin
    if (busy) begin
      mem[idx(clr_addr)] <= '0;
    end else if (wr_en) begin
      for (int b = 0; b < NB; b++) begin
        if (wmask0[b]) mem[idx(addr0)][8*b +: 8] <= din0[8*b +: 8];
      end
    end
  end

  always_comb begin
    rd_word = in_range(addr1) ? mem[idx(addr1)] : '0;
    if (BYPASS != 0 && wr_en && (addr0 == addr1)) begin
      for (int b = 0; b < NB; b++) begin
        if (wmask0[b]) rd_word[8*b +: 8] = din0[8*b +: 8];
      end
    end
  end

  generate
    if (RD_LAT == 2) begin : g_lat2
      logic          p_valid;
      logic [DW-1:0] p_data;

      // A pending read is squashed when the clear request takes its completion edge.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          p_valid <= 1'b0;
          p_data  <= '0;
          dout1   <= '0;
          dvalid1 <= 1'b0;
        end else begin
          p_valid <= rd_en;
          if (rd_en) p_data <= rd_word;
          dvalid1 <= p_valid && port_en;
          if (p_valid && port_en) dout1 <= p_data;
        end
      end
    end else begin : g_lat1
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          dout1   <= '0;
          dvalid1 <= 1'b0;
        end else begin
          dvalid1 <= rd_en;
          if (rd_en) dout1 <= rd_word;
        end
      end
    end
  endgenerate

endmodule
